gmm_fg_mode_sched: RTL

Frame-synchronous display-mode scheduler for the foreground-visor output stage. It synchronizes and debounces the board mode switches, and can optionally auto-cycle modes every N frames. It monitors the Avalon-ST handshake feeding the visor and applies a new 2-bit mode only at the start of a video packet, so no frame is ever rendered in mixed modes. Its `mode` output drives the visor `sw` input; the monitor ports tap the visor sink interface passively.

---
 rtl/gmm_fg_mode_sched.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/gmm_fg_mode_sched.sv
// Frame-synchronous display-mode scheduler for the foreground visor.
// Synchronizes and debounces the mode switches, optionally auto-cycles the
// mode every AUTO_FRAMES video frames, and applies a new mode only on the
// start-of-packet beat of a video packet seen on the monitored Avalon-ST link.
module gmm_fg_mode_sched #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned AUTO_FRAMES     = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  sw_raw,
  input  logic        auto_en,
  input  logic        mon_valid,
  input  logic        mon_ready,
  input  logic        mon_sop,
  input  logic        mon_eop,
  input  logic [3:0]  mon_type,
  output logic [1:0]  mode,
  output logic        mode_pending,
  output logic        mode_changed,
  output logic [15:0] frame_cnt
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned AW = $clog2(AUTO_FRAMES + 1);
  localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW-1:0] AF_LAST = AW'(AUTO_FRAMES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_VIDEO, ST_CTRL} state_t;

  state_t        state, state_nxt;
  logic [1:0]    sw_s1, sw_s2, sw_cand, sw_stable;
  logic          ae_s1, ae_s2, ae_cand, auto_stable;
  logic [DW-1:0] sw_cnt, ae_cnt;
  logic [AW-1:0] auto_frames;
  logic [1:0]    auto_mode;
  logic [1:0]    req_mode;
  logic          beat, is_video, apply, frame_inc;

  assign beat     = mon_valid & mon_ready;
  assign is_video = (mon_type == 4'd0);
  assign req_mode = auto_stable ? auto_mode : sw_stable;
  assign mode_pending = (req_mode != mode);

  // Two-flop synchronizers for the asynchronous board switches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
      ae_s1 <= 1'b0;
      ae_s2 <= 1'b0;
    end else begin
      sw_s1 <= sw_raw;
      sw_s2 <= sw_s1;
      ae_s1 <= auto_en;
      ae_s2 <= ae_s1;
    end
  end

  // Debounce of the mode switches: accept a value once it has held long enough
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_cand   <= '0;
      sw_cnt    <= '0;
      sw_stable <= '0;
    end else if (sw_s2 != sw_cand) begin
      sw_cand <= sw_s2;
      sw_cnt  <= '0;
    end else if (sw_cnt != DB_MAX) begin
      sw_cnt <= sw_cnt + DW'(1);
    end else begin
      sw_stable <= sw_cand;
    end
  end

  // Debounce of the auto-cycle enable switch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ae_cand     <= 1'b0;
      ae_cnt      <= '0;
      auto_stable <= 1'b0;
    end else if (ae_s2 != ae_cand) begin
      ae_cand <= ae_s2;
      ae_cnt  <= '0;
    end else if (ae_cnt != DB_MAX) begin
      ae_cnt <= ae_cnt + DW'(1);
    end else begin
      auto_stable <= ae_cand;
    end
  end

  // Stream FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Stream FSM next state; any sop beat restarts packet tracking from scratch
  always_comb begin
    state_nxt = state;
    if (beat) begin
      if (mon_sop) begin
        if (mon_eop)       state_nxt = ST_IDLE;
        else if (is_video) state_nxt = ST_VIDEO;
        else               state_nxt = ST_CTRL;
      end else if (mon_eop) begin
        state_nxt = ST_IDLE;
      end
    end
  end

  // Stream FSM outputs: mode-apply strobe and completed-frame strobe
  always_comb begin
    apply     = 1'b0;
    frame_inc = 1'b0;
    if (beat && mon_sop) begin
      apply     = is_video;
      frame_inc = is_video & mon_eop;
    end else if (beat && mon_eop && (state == ST_VIDEO)) begin
      frame_inc = 1'b1;
    end
  end

  // Applied mode and its change pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode         <= '0;
      mode_changed <= 1'b0;
    end else if (apply) begin
      mode         <= req_mode;
      mode_changed <= (req_mode != mode);
    end else begin
      mode_changed <= 1'b0;
    end
  end

  // Completed video frame counter (wraps)
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            frame_cnt <= '0;
    else if (frame_inc) frame_cnt <= frame_cnt + 16'd1;
  end

  // Auto-cycle: step the mode every AUTO_FRAMES counted frames while enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auto_frames <= '0;
      auto_mode   <= '0;
    end else if (!auto_stable) begin
      auto_frames <= '0;
    end else if (frame_inc) begin
      if (auto_frames == AF_LAST) begin
        auto_frames <= '0;
        auto_mode   <= auto_mode + 2'd1;
      end else begin
        auto_frames <= auto_frames + AW'(1);
      end
    end
  end

endmodule
